alu_operand_issue: RTL and testbench

- Buffers 64-bit operand words `{src_1, src_2}` in a FIFO.
- Issues one pair per cycle to the combinational 33-bit ALU.
- Captures each ALU result, together with its operands, in an output register with a valid/ready handshake.
- Sits upstream of the ALU, feeding its `src_1`/`src_2` inputs, and directly downstream of it, consuming `result`. This turns the combinational ALU into a streaming, back-pressurable pipeline stage.

---
 rtl/alu_operand_issue.sv | 160 ++++++++++++++++
 tb/tb_alu_operand_issue.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_issue.sv
// alu_operand_issue
// Streaming wrapper around a combinational ALU: operand words are queued in
// a small FIFO, issued one pair per cycle to the ALU through the src_1/src_2
// registers, and each result is captured with its operands in an output
// register that supports valid/ready backpressure.
module alu_operand_issue #(
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [2*DATA_WIDTH-1:0]          in_data,
  output logic [DATA_WIDTH-1:0]            src_1,
  output logic [DATA_WIDTH-1:0]            src_2,
  input  logic [DATA_WIDTH:0]              alu_result,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [DATA_WIDTH-1:0]            out_src_1,
  output logic [DATA_WIDTH-1:0]            out_src_2,
  output logic [DATA_WIDTH:0]              out_result,
  output logic [$clog2(DEPTH):0]           count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);
  localparam logic [PTR_W-1:0] ONE_PTR  = PTR_W'(1);

  // FIFO storage and bookkeeping
  logic [2*DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]        r_wr_ptr;
  logic [PTR_W-1:0]        r_rd_ptr;
  logic [CNT_W-1:0]        r_count;

  // Operand stage
  logic                    r_op_valid;
  logic [DATA_WIDTH-1:0]   r_src_1;
  logic [DATA_WIDTH-1:0]   r_src_2;

  // Result stage
  logic                    r_out_valid;
  logic [DATA_WIDTH-1:0]   r_out_src_1;
  logic [DATA_WIDTH-1:0]   r_out_src_2;
  logic [DATA_WIDTH:0]     r_out_result;

  // Handshake / stage-advance strobes
  logic                    w_in_ready;
  logic                    w_push;
  logic                    w_res_load;
  logic                    w_op_load;
  logic [2*DATA_WIDTH-1:0] w_head;

  // Stage-advance decisions; the result stage frees first so the operand
  // stage can refill in the same cycle, giving one result per cycle.
  always_comb begin
    w_in_ready = 1'b0;
    if (rst_n) begin
      w_in_ready = (r_count != FULL_CNT);
    end else begin
      w_in_ready = 1'b0;
    end
    w_push     = in_valid && w_in_ready;
    w_res_load = r_op_valid && (!r_out_valid || out_ready);
    w_op_load  = (r_count != {CNT_W{1'b0}}) && (!r_op_valid || w_res_load);
    w_head     = r_mem[r_rd_ptr];
  end

  // FIFO data write; entries are not reset, occupancy tracking makes them don't-care
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= in_data;
    end else begin
      r_mem[r_wr_ptr] <= r_mem[r_wr_ptr];
    end
  end

  // FIFO pointers and occupancy counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      r_count  <= {CNT_W{1'b0}};
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + ONE_PTR;
      end else begin
        r_wr_ptr <= r_wr_ptr;
      end
      if (w_op_load) begin
        r_rd_ptr <= r_rd_ptr + ONE_PTR;
      end else begin
        r_rd_ptr <= r_rd_ptr;
      end
      case ({w_push, w_op_load})
        2'b10:   r_count <= r_count + ONE_CNT;
        2'b01:   r_count <= r_count - ONE_CNT;
        default: r_count <= r_count;
      endcase
    end
  end

  // Operand stage: load the FIFO head into the ALU operand registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_op_valid <= 1'b0;
      r_src_1    <= {DATA_WIDTH{1'b0}};
      r_src_2    <= {DATA_WIDTH{1'b0}};
    end else if (w_op_load) begin
      r_op_valid <= 1'b1;
      r_src_1    <= w_head[2*DATA_WIDTH-1:DATA_WIDTH];
      r_src_2    <= w_head[DATA_WIDTH-1:0];
    end else if (w_res_load) begin
      r_op_valid <= 1'b0;
      r_src_1    <= r_src_1;
      r_src_2    <= r_src_2;
    end else begin
      r_op_valid <= r_op_valid;
      r_src_1    <= r_src_1;
      r_src_2    <= r_src_2;
    end
  end

  // Result stage: capture ALU output with its operands, hold under backpressure
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_out_src_1  <= {DATA_WIDTH{1'b0}};
      r_out_src_2  <= {DATA_WIDTH{1'b0}};
      r_out_result <= {(DATA_WIDTH+1){1'b0}};
    end else if (w_res_load) begin
      r_out_valid  <= 1'b1;
      r_out_src_1  <= r_src_1;
      r_out_src_2  <= r_src_2;
      r_out_result <= alu_result;
    end else if (r_out_valid && out_ready) begin
      r_out_valid  <= 1'b0;
      r_out_src_1  <= r_out_src_1;
      r_out_src_2  <= r_out_src_2;
      r_out_result <= r_out_result;
    end else begin
      r_out_valid  <= r_out_valid;
      r_out_src_1  <= r_out_src_1;
      r_out_src_2  <= r_out_src_2;
      r_out_result <= r_out_result;
    end
  end

  assign in_ready   = w_in_ready;
  assign src_1      = r_src_1;
  assign src_2      = r_src_2;
  assign out_valid  = r_out_valid;
  assign out_src_1  = r_out_src_1;
  assign out_src_2  = r_out_src_2;
  assign out_result = r_out_result;
  assign count      = r_count;

endmodule

// File: tb/tb_alu_operand_issue.sv
// Self-checking bench for alu_operand_issue with a 33-bit adder as the ALU.
module tb_alu_operand_issue;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic [31:0] src_1;
  logic [31:0] src_2;
  logic [32:0] alu_result;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_src_1;
  logic [31:0] out_src_2;
  logic [32:0] out_result;
  logic [2:0]  count;

  int n_checks = 0;
  int n_errors = 0;

  alu_operand_issue #(.DEPTH(4), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .src_1(src_1), .src_2(src_2), .alu_result(alu_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_src_1(out_src_1), .out_src_2(out_src_2), .out_result(out_result),
    .count(count)
  );

  // Attached ALU: 33-bit adder
  assign alu_result = {1'b0, src_1} + {1'b0, src_2};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] mk(input int i);
    logic [31:0] hi;
    logic [31:0] lo;
    hi = 32'h1000_0000 + 32'(i);
    lo = 32'h0000_0100 + 32'(i);
    return {hi, lo};
  endfunction

  // Scoreboard: handshakes are evaluated on the falling edge, i.e. the
  // values the next rising edge will act on.
  logic [63:0] sb_q[$];
  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
    end else begin
      if (in_valid && in_ready) sb_q.push_back(in_data);
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check("sb_unexpected_result", {31'd0, out_result}, 64'd0);
        end else begin
          logic [63:0] e;
          logic [32:0] er;
          e  = sb_q.pop_front();
          er = {1'b0, e[63:32]} + {1'b0, e[31:0]};
          check("sb_src_1",  {32'd0, out_src_1}, {32'd0, e[63:32]});
          check("sb_src_2",  {32'd0, out_src_2}, {32'd0, e[31:0]});
          check("sb_result", {31'd0, out_result}, {31'd0, er});
        end
      end
    end
  end

  typedef struct {
    logic [63:0] data;
    logic [32:0] res;
  } vec_t;

  vec_t        vecs[7];
  logic [63:0] last_pushed;
  int          accepted;
  int          seq;
  logic        acc_now;
  int          maxcnt;
  int          nvalid;
  int          first_valid;

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) tick();
  endtask

  task automatic single_word(input string tag, input logic [63:0] d, input logic [32:0] r);
    if (!in_ready) begin
      check({tag, "_in_ready"}, {63'd0, in_ready}, 64'd1);
    end
    in_data  = d;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check({tag, "_count1"}, {61'd0, count}, 64'd1);
    tick();
    check({tag, "_valid_early"}, {63'd0, out_valid}, 64'd0);
    check({tag, "_src_1"}, {32'd0, src_1}, {32'd0, d[63:32]});
    check({tag, "_src_2"}, {32'd0, src_2}, {32'd0, d[31:0]});
    tick();
    check({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
    check({tag, "_result"}, {31'd0, out_result}, {31'd0, r});
    check({tag, "_out_src_1"}, {32'd0, out_src_1}, {32'd0, d[63:32]});
    check({tag, "_out_src_2"}, {32'd0, out_src_2}, {32'd0, d[31:0]});
    check({tag, "_count0"}, {61'd0, count}, 64'd0);
    tick();
    check({tag, "_valid_gone"}, {63'd0, out_valid}, 64'd0);
    last_pushed = d;
  endtask

  initial begin
    vecs[0] = '{64'h00000001_00000002, 33'h0_0000_0003};
    vecs[1] = '{64'hFFFFFFFF_00000001, 33'h1_0000_0000};
    vecs[2] = '{64'h80000000_80000000, 33'h1_0000_0000};
    vecs[3] = '{64'h00000000_00000000, 33'h0_0000_0000};
    vecs[4] = '{64'h12345678_9ABCDEF0, 33'h0_ACF1_3568};
    vecs[5] = '{64'hFFFFFFFF_FFFFFFFF, 33'h1_FFFF_FFFE};
    vecs[6] = '{64'h7FFFFFFF_00000001, 33'h0_8000_0000};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 64'd0;
    out_ready = 1'b1;
    last_pushed = 64'd0;

    // Reset state
    #1;
    check("rst_in_ready_low", {63'd0, in_ready}, 64'd0);
    tick(); tick();
    check("rst_count", {61'd0, count}, 64'd0);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_src_1", {32'd0, src_1}, 64'd0);
    check("rst_out_result", {31'd0, out_result}, 64'd0);
    rst_n = 1'b1;
    #1;
    check("rst_release_in_ready", {63'd0, in_ready}, 64'd1);
    tick();

    // Table-driven single-word transactions
    for (int i = 0; i < 7; i++) begin
      single_word($sformatf("vec%0d", i), vecs[i].data, vecs[i].res);
    end

    // Backpressure fill: exactly DEPTH+2 words accepted, head result held stable
    out_ready = 1'b0;
    in_valid  = 1'b1;
    seq       = 0;
    accepted  = 0;
    in_data   = mk(seq);
    for (int c = 0; c < 10; c++) begin
      acc_now = in_ready;
      tick();
      if (acc_now) begin
        accepted++;
        last_pushed = in_data;
        seq++;
        in_data = mk(seq);
      end
      if (out_valid) begin
        check("stall_out_src_1", {32'd0, out_src_1}, {32'd0, mk(0) >> 32});
        check("stall_out_result", {31'd0, out_result},
              {31'd0, {1'b0, mk(0) >> 32} + {1'b0, mk(0) & 64'hFFFF_FFFF}});
      end
    end
    in_valid = 1'b0;
    check("fill_accepted", 64'(accepted), 64'd6);
    check("fill_in_ready", {63'd0, in_ready}, 64'd0);
    check("fill_count", {61'd0, count}, 64'd4);
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      check($sformatf("burst_valid%0d", k), {63'd0, out_valid}, 64'd1);
      tick();
    end
    check("burst_done", {63'd0, out_valid}, 64'd0);
    drain();

    // Streaming: 16 back-to-back words
    out_ready   = 1'b1;
    maxcnt      = 0;
    nvalid      = 0;
    first_valid = -1;
    for (int c = 0; c < 20; c++) begin
      if (c < 16) begin
        in_valid = 1'b1;
        in_data  = mk(100 + c);
        if (!in_ready) check("stream_in_ready", {63'd0, in_ready}, 64'd1);
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (c < 16) last_pushed = mk(100 + c);
      if (int'(count) > maxcnt) maxcnt = int'(count);
      if (out_valid) begin
        nvalid++;
        if (first_valid < 0) first_valid = c;
      end
    end
    in_valid = 1'b0;
    check("stream_max_count", 64'(maxcnt), 64'd1);
    check("stream_nvalid", 64'(nvalid), 64'd16);
    check("stream_latency", 64'(first_valid), 64'd2);
    drain();

    // Simultaneous push/pop at count=2
    out_ready = 1'b0;
    in_valid  = 1'b1;
    seq       = 200;
    for (int k = 0; k < 4; k++) begin
      in_data = mk(seq);
      tick();
      last_pushed = mk(seq);
      seq++;
    end
    check("pp_count_init", {61'd0, count}, 64'd2);
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_data = mk(seq);
      tick();
      last_pushed = mk(seq);
      seq++;
      check($sformatf("pp_count%0d", k), {61'd0, count}, 64'd2);
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    tick();
    check("pp_count_stall", {61'd0, count}, 64'd2);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = mk(seq);
    tick();
    last_pushed = mk(seq);
    seq++;
    check("pp_count_again", {61'd0, count}, 64'd2);
    drain();

    // Idle: nothing emitted, operand registers keep the last word
    for (int k = 0; k < 10; k++) begin
      tick();
      if (out_valid) check("idle_out_valid", {63'd0, out_valid}, 64'd0);
    end
    check("idle_out_valid_end", {63'd0, out_valid}, 64'd0);
    check("idle_src_1", {32'd0, src_1}, {32'd0, last_pushed[63:32]});
    check("idle_src_2", {32'd0, src_2}, {32'd0, last_pushed[31:0]});

    // Reset mid-stream with three words in flight
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_data = mk(300 + k);
      tick();
    end
    in_valid = 1'b0;
    check("mid_out_valid_before", {63'd0, out_valid}, 64'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", {63'd0, in_ready}, 64'd0);
    tick();
    check("mid_rst_count", {61'd0, count}, 64'd0);
    check("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("mid_rst_src_1", {32'd0, src_1}, 64'd0);
    check("mid_rst_src_2", {32'd0, src_2}, 64'd0);
    check("mid_rst_out_src_1", {32'd0, out_src_1}, 64'd0);
    check("mid_rst_out_src_2", {32'd0, out_src_2}, 64'd0);
    check("mid_rst_out_result", {31'd0, out_result}, 64'd0);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (out_valid) check("post_rst_stale", {63'd0, out_valid}, 64'd0);
    end
    check("post_rst_idle", {63'd0, out_valid}, 64'd0);
    single_word("post_rst", 64'h00000005_00000006, 33'h0_0000_000B);

    check("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
